// File: rtl/fast_corner_reader.sv
// fast_corner_reader
// Raster-scans the FAST corner SRAM and streams every set flag out as an (x, y)
// coordinate record through a small FIFO.
//
// Handshake: a record transfers on a rising edge where corner_valid && corner_ready.
// corner_valid depends only on FIFO occupancy, never on corner_ready, and the head
// stays stable until it is popped.
//
// Optional feature: define FAST_CORNER_COUNT_EN to build the corner_count counter.
// Without it, corner_count is tied to 0.
//
// n_rst is active-high and synchronous despite its name.
module fast_corner_reader #(
    parameter int X_MAX      = 5,
    parameter int Y_MAX      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                start,
    input  logic [$clog2(X_MAX)-1:0]            max_x,
    input  logic [$clog2(X_MAX)-1:0]            max_y,
    output logic                                read_SRAM_fast,
    output logic signed [$clog2(X_MAX):0]       x_addr_fast,
    output logic signed [$clog2(X_MAX):0]       y_addr_fast,
    input  logic                                SRAM_in_fast,
    output logic                                corner_valid,
    input  logic                                corner_ready,
    output logic [$clog2(X_MAX)-1:0]            corner_x,
    output logic [$clog2(X_MAX)-1:0]            corner_y,
    output logic [$clog2(X_MAX*Y_MAX):0]        corner_count,
    output logic                                busy,
    output logic                                done,
    output logic [1:0]                          state_dbg_o
);

    localparam int XW = $clog2(X_MAX);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(X_MAX * Y_MAX) + 1;
    localparam logic [PW+1:0] DEPTH_L = (PW + 2)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Scan bookkeeping
    logic [XW-1:0] x_q, y_q;          // address of the next read to issue
    logic [XW-1:0] mx_q, my_q;        // frame limits latched on start
    logic [XW-1:0] rd_x_q, rd_y_q;    // address of the read whose data arrives now
    logic          in_flight_q;       // a read was issued last cycle
    logic          rd_done_q;         // the final pixel's read has been issued

    // Coordinate FIFO
    logic [2*XW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic [2*XW-1:0] head;

    logic            start_acc;
    logic            rd_en;
    logic            last_pix;
    logic            push, pop;
    logic [PW+1:0]   occupancy;

    assign start_acc = (state_q == S_IDLE) && start;
    assign last_pix  = (x_q == mx_q) && (y_q == my_q);
    assign push      = in_flight_q && SRAM_in_fast;
    assign pop       = corner_valid && corner_ready;
    // In-flight reads count as occupied slots so their flags always have room.
    assign occupancy = {1'b0, count_q} + {{(PW + 1){1'b0}}, in_flight_q};

    // State register
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SCAN;
            // Leave at the edge that consumes the last read's data.
            S_SCAN:  if (rd_done_q && in_flight_q) state_d = S_DRAIN;
            S_DRAIN: if (count_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: read strobe with back-pressure, busy and done
    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_SCAN: begin
                busy  = 1'b1;
                rd_en = !rd_done_q && (occupancy < DEPTH_L);
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign read_SRAM_fast = rd_en;
    assign x_addr_fast    = {1'b0, x_q};
    assign y_addr_fast    = {1'b0, y_q};
    assign state_dbg_o    = state_q;

    // Raster address generator and in-flight tracking
    always_ff @(posedge clk) begin
        if (n_rst) begin
            x_q         <= '0;
            y_q         <= '0;
            mx_q        <= '0;
            my_q        <= '0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            in_flight_q <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            in_flight_q <= rd_en;
            if (start_acc) begin
                mx_q      <= max_x;
                my_q      <= max_y;
                x_q       <= '0;
                y_q       <= '0;
                rd_done_q <= 1'b0;
            end else if (rd_en) begin
                rd_x_q <= x_q;
                rd_y_q <= y_q;
                if (last_pix) begin
                    rd_done_q <= 1'b1;
                    x_q       <= '0;
                    y_q       <= '0;
                end else if (x_q == mx_q) begin
                    x_q <= '0;
                    y_q <= y_q + XW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end

    // FIFO occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and count
    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {rd_x_q, rd_y_q};
    end

    assign head         = mem_q[rd_ptr_q];
    assign corner_valid = (count_q != '0);
    assign corner_x     = corner_valid ? head[2*XW-1:XW] : '0;
    assign corner_y     = corner_valid ? head[XW-1:0]    : '0;

`ifdef FAST_CORNER_COUNT_EN
    logic [CW-1:0] cnt_q;

    // Corners found this scan; clears on accepted start, saturates at all-ones
    always_ff @(posedge clk) begin
        if (n_rst) begin
            cnt_q <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
        end else if (push && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign corner_count = cnt_q;
`else
    assign corner_count = '0;
`endif

endmodule

// File: tb/tb_fast_corner_reader.sv
// Bench for fast_corner_reader: emulates the FAST SRAM from a bit map, predicts the
// raster read sequence and the record stream from the map, and checks every cycle.
module tb_fast_corner_reader;

  localparam int X_MAX      = 5;
  localparam int Y_MAX      = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int XW         = 3;
  localparam int CW         = 6;
`ifdef FAST_CORNER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // clock / reset block
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic                 start;
  logic [XW-1:0]        max_x, max_y;
  logic                 read_SRAM_fast;
  logic signed [XW:0]   x_addr_fast, y_addr_fast;
  logic                 SRAM_in_fast;
  logic                 corner_valid;
  logic                 corner_ready;
  logic [XW-1:0]        corner_x, corner_y;
  logic [CW-1:0]        corner_count;
  logic                 busy, done;
  logic [1:0]           state_dbg;

  fast_corner_reader #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .max_x          (max_x),
    .max_y          (max_y),
    .read_SRAM_fast (read_SRAM_fast),
    .x_addr_fast    (x_addr_fast),
    .y_addr_fast    (y_addr_fast),
    .SRAM_in_fast   (SRAM_in_fast),
    .corner_valid   (corner_valid),
    .corner_ready   (corner_ready),
    .corner_x       (corner_x),
    .corner_y       (corner_y),
    .corner_count   (corner_count),
    .busy           (busy),
    .done           (done),
    .state_dbg_o    (state_dbg)
  );

  int n_cmp = 0;
  int n_fail = 0;

  bit map [0:7][0:7];
  logic [2*XW-1:0] exp_q[$];     // expected records, raster order
  logic [2*XW-1:0] exp_rd_q[$];  // expected read addresses, raster order

  bit chk_en = 1'b0;
  bit data_pend = 1'b0;
  bit data_flag = 1'b0;
  int found = 0;
  int reads_n = 0;
  int done_n = 0;
  int since_start = 0;
  int first_valid = -1;
  int reads_before_pop = 0;
  bit popped = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  // SRAM emulation: flag for last cycle's read, noise otherwise
  always @(posedge clk) begin
    #1;
    SRAM_in_fast = data_pend ? data_flag : 1'($urandom_range(0, 1));
  end

  // scoreboard / compare process
  always @(negedge clk) begin
    if (chk_en) begin
      since_start++;
      check("corner_count", 32'(corner_count), CNT_EN ? ((found > 63) ? 63 : found) : 0);
      if (data_pend && data_flag) found++;
      if (read_SRAM_fast) begin
        reads_n++;
        if (!popped) reads_before_pop++;
        if (exp_rd_q.size() == 0) begin
          fail_now("extra_read");
        end else begin
          check("read_addr", 32'({x_addr_fast, y_addr_fast}),
                32'({1'b0, exp_rd_q[0][5:3], 1'b0, exp_rd_q[0][2:0]}));
          void'(exp_rd_q.pop_front());
        end
      end
      if (corner_valid) begin
        if (first_valid < 0) first_valid = since_start;
        if (exp_q.size() == 0) begin
          fail_now("extra_record");
        end else begin
          check("record", 32'({corner_x, corner_y}), 32'(exp_q[0]));
          if (corner_ready) begin
            void'(exp_q.pop_front());
            popped = 1'b1;
          end
        end
      end else begin
        check("idle_head", 32'({corner_x, corner_y}), 0);
      end
      if (done) begin
        done_n++;
        check("busy_at_done", 32'(busy), 0);
      end
    end
    data_pend = read_SRAM_fast;
    data_flag = map[x_addr_fast[2:0]][y_addr_fast[2:0]];
  end

  // driver tasks
  task automatic clear_map();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        map[x][y] = 1'b0;
  endtask

  task automatic build_model(input int mx, input int my);
    exp_q.delete();
    exp_rd_q.delete();
    for (int y = 0; y <= my; y++)
      for (int x = 0; x <= mx; x++) begin
        exp_rd_q.push_back({3'(x), 3'(y)});
        if (map[x][y]) exp_q.push_back({3'(x), 3'(y)});
      end
  endtask

  task automatic pulse_start(input int mx, input int my);
    @(posedge clk);
    #1;
    start = 1'b1;
    max_x = 3'(mx);
    max_y = 3'(my);
    @(posedge clk);
    found = 0;
    since_start = 0;
    first_valid = -1;
    reads_n = 0;
    done_n = 0;
    reads_before_pop = 0;
    popped = 1'b0;
    #1;
    start = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_read"}, 32'(read_SRAM_fast), 0);
    check({tag, "_xaddr"}, 32'(x_addr_fast), 0);
    check({tag, "_yaddr"}, 32'(y_addr_fast), 0);
    check({tag, "_valid"}, 32'(corner_valid), 0);
    check({tag, "_head"}, 32'({corner_x, corner_y}), 0);
    check({tag, "_count"}, 32'(corner_count), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_state"}, 32'(state_dbg), 0);
  endtask

  task automatic run_scan(input string tag, input int mx, input int my, input int hold,
                          input bit poke, input int lit_reads, input int lit_recs,
                          input int lit_first, input int lit_rbp);
    int cyc;
    build_model(mx, my);
    check({tag, "_model_reads"}, 32'(exp_rd_q.size()), lit_reads);
    check({tag, "_model_recs"}, 32'(exp_q.size()), lit_recs);
    corner_ready = (hold == 0);
    pulse_start(mx, my);
    @(negedge clk);
    check({tag, "_busy_after_start"}, 32'(busy), 1);
    cyc = 0;
    while (done_n == 0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      corner_ready = (cyc >= hold);
      if (poke && cyc == 5) begin
        start = 1'b1;
        max_x = 3'd1;
        max_y = 3'd0;
      end else begin
        start = 1'b0;
      end
    end
    if (done_n == 0) fail_now({tag, "_timeout"});
    repeat (3) @(negedge clk);
    check({tag, "_reads"}, 32'(reads_n), lit_reads);
    check({tag, "_left"}, 32'(exp_q.size()), 0);
    check({tag, "_done_pulses"}, 32'(done_n), 1);
    check({tag, "_first_valid"}, 32'(first_valid), 32'(lit_first));
    check({tag, "_reads_before_pop"}, 32'(reads_before_pop), lit_rbp);
    check({tag, "_final_count"}, 32'(corner_count), CNT_EN ? lit_recs : 0);
    check({tag, "_idle"}, 32'(state_dbg), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b1;
    start = 1'b0;
    corner_ready = 1'b0;
    max_x = '0;
    max_y = '0;
    SRAM_in_fast = 1'b0;
    clear_map();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("por");
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    chk_en = 1'b1;

    // 3x3, corners at (1,0) and (2,2), start poked mid-scan with other limits
    clear_map();
    map[1][0] = 1'b1;
    map[2][2] = 1'b1;
    run_scan("map3x3", 2, 2, 0, 1'b1, 9, 2, 4, 4);
    check("map3x3_first_rec_lit", 32'({3'd1, 3'd0}), 32'({map[1][0] ? 3'd1 : 3'd7, 3'd0}));

    // all-ones 4x4 with the consumer stalled for 20 cycles
    clear_map();
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        map[x][y] = 1'b1;
    run_scan("ones4x4", 3, 3, 20, 1'b0, 16, 16, 3, 4);

    // all-zero 5x5
    clear_map();
    run_scan("zero5x5", 4, 4, 0, 1'b0, 25, 0, -1, 25);

    // single pixel
    clear_map();
    map[0][0] = 1'b1;
    run_scan("single", 0, 0, 0, 1'b0, 1, 1, 3, 1);

    // 5x2 checkerboard, consumer late: a zero flag in flight still reserves a slot
    clear_map();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 2; y++)
        map[x][y] = ((x + y) % 2 == 0);
    run_scan("checker", 4, 1, 7, 1'b0, 10, 5, 3, 7);

    // reset mid-scan with three records queued, then rescan
    clear_map();
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        map[x][y] = 1'b1;
    build_model(3, 3);
    corner_ready = 1'b0;
    pulse_start(3, 3);
    repeat (4) @(posedge clk);
    #1;
    n_rst = 1'b1;
    chk_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_checks("midrst");
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    exp_q.delete();
    exp_rd_q.delete();
    found = 0;
    chk_en = 1'b1;
    run_scan("rescan", 3, 3, 0, 1'b0, 16, 16, 3, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
